// File: rtl/kadai4_arb_pkg.sv
// Shared types and constants for the two-source kadai4 arbiter.
package kadai4_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    STOP  = 2'd3
  } arb_state_e;

  localparam int NSRC          = 2;
  localparam int TAG_DEPTH_DEF = 4;

  function automatic logic [NSRC-1:0] src_onehot(input logic src);
    src_onehot = src ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/kadai4_tag_fifo.sv
// 1-bit tag FIFO recording which source issued each in-flight operand pair.
module kadai4_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic pop_tag,
  output logic full,
  output logic empty
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_tag = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kadai4_arbiter.sv
// Round-robin sharing of one kadai4 multiply unit between two operand sources,
// with per-pair source tags so each returned X goes back to its issuer.
module kadai4_arbiter
  import kadai4_arb_pkg::*;
#(
  parameter int DW        = 8,
  parameter int XW        = 16,
  parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic [NSRC-1:0]      SRC_REQ,
  input  logic [NSRC*DW-1:0]   SRC_A,
  input  logic [NSRC*DW-1:0]   SRC_B,
  output logic [NSRC-1:0]      SRC_ACK,
  output logic [DW-1:0]        U_A,
  output logic [DW-1:0]        U_B,
  output logic                 U_ACK,
  input  logic                 U_REQ_AB,
  output logic                 U_START,
  output logic                 U_HALT,
  input  logic [XW-1:0]        U_X,
  input  logic                 U_X_VALID,
  output logic [XW-1:0]        DST_X,
  output logic [NSRC-1:0]      DST_VALID,
  output logic                 BUSY,
  output logic                 ERR,
  output arb_state_e           dbg_state
);

  // Handshakes: SRC_REQ[i] is valid for source i's pair; SRC_ACK[i] is a one-cycle
  // pop strobe. U_REQ_AB means the unit wants operands; U_ACK is a one-cycle strobe
  // delivering U_A/U_B, never on back-to-back cycles. U_X_VALID/DST_VALID are strobes.
  arb_state_e state;
  arb_state_e state_nx;
  logic       last_grant;
  logic       grant;
  logic       issue;
  logic       pop;
  logic       head_tag;
  logic       fifo_full;
  logic       fifo_empty;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (EN) state_nx = RUN;
      RUN:     if (!EN) state_nx = DRAIN;
      DRAIN:   if (fifo_empty) state_nx = STOP;
      STOP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    U_START   = (state == RUN) || (state == DRAIN);
    U_HALT    = (state == STOP);
    BUSY      = (state != IDLE);
    dbg_state = state;
  end

  // A lone requester wins outright; with both requesting, the one not served last wins.
  always_comb begin
    grant = ~last_grant;
    if (SRC_REQ == 2'b01)      grant = 1'b0;
    else if (SRC_REQ == 2'b10) grant = 1'b1;
  end

  assign issue = (state == RUN) & U_REQ_AB & ~U_ACK & (|SRC_REQ) & ~fifo_full;
  assign pop   = U_X_VALID & ~fifo_empty;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      U_ACK      <= 1'b0;
      SRC_ACK    <= '0;
      U_A        <= '0;
      U_B        <= '0;
      last_grant <= 1'b1;
      DST_X      <= '0;
      DST_VALID  <= '0;
      ERR        <= 1'b0;
    end else begin
      U_ACK   <= issue;
      SRC_ACK <= issue ? src_onehot(grant) : '0;
      if (issue) begin
        U_A        <= SRC_A[DW*int'(grant) +: DW];
        U_B        <= SRC_B[DW*int'(grant) +: DW];
        last_grant <= grant;
      end
      DST_VALID <= pop ? src_onehot(head_tag) : '0;
      if (pop) DST_X <= U_X;
      if (U_X_VALID && fifo_empty) ERR <= 1'b1;
    end
  end

  kadai4_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (issue),
    .push_tag (grant),
    .pop      (pop),
    .pop_tag  (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule
